riscv_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It generates per-stage stall (hold) and flush (bubble) controls for load-use hazards, multi-cycle MDU operations, data-memory wait states and taken branches. It complements the forwarding unit: it covers exactly the hazards that forwarding cannot resolve. It sits beside the pipeline registers and drives their enables and clears directly.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/riscv_sat_counter.sv | 23 ++
 rtl/riscv_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the ranked hazard causes.
package riscv_pkg;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MDU, S_MEM} hazard_state_e;

  // Encoded value doubles as priority: a larger value masks every smaller one.
  typedef enum logic [2:0] {
    HZ_NONE      = 3'd0,
    HZ_LOAD_USE  = 3'd1,
    HZ_BRANCH    = 3'd2,
    HZ_MDU       = 3'd3,
    HZ_MEM       = 3'd4
  } hazard_e;

  function automatic hazard_e hazard_pick(input logic mem_wait, input logic mdu,
                                          input logic branch, input logic load_use);
    if (mem_wait)      return HZ_MEM;
    else if (mdu)      return HZ_MDU;
    else if (branch)   return HZ_BRANCH;
    else if (load_use) return HZ_LOAD_USE;
    else               return HZ_NONE;
  endfunction

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter for performance events; clr beats inc, holds at all-ones.
// Single-cycle update, no backpressure.
module riscv_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (clr)                    cnt_q <= '0;
    else if (inc && (cnt_q != '1))   cnt_q <= cnt_q + WIDTH'(1);
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: controls are same-cycle combinational
// from state and inputs; bus_err, state and counters are registered.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_if2id_ff,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_if2id_ff,
  input  logic                     use_rs1_id,
  input  logic                     use_rs2_id,
  input  logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff,
  input  logic                     mem_read_id2ex_ff,
  input  logic                     mdu_start_ex,
  input  logic                     mdu_done,
  input  logic                     branch_taken_ex,
  input  logic                     dmem_req_mem,
  input  logic                     dmem_ack,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     stall_ex,
  output logic                     stall_mem,
  output logic                     flush_id,
  output logic                     flush_ex,
  output logic                     flush_mem,
  output logic                     flush_wb,
  output logic                     mdu_go,
  output logic                     bus_err,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  input  logic                     clr_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  hazard_state_e  state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           pend_q, pend_d;
  logic           bus_err_q, bus_err_d;

  logic    mem_wait, load_use, timeout;
  hazard_e cause;

  assign mem_wait = dmem_req_mem & ~dmem_ack;
  assign load_use = mem_read_id2ex_ff & (rd_id2ex_ff != '0) &
                    ((use_rs1_id & (rs1_if2id_ff == rd_id2ex_ff)) |
                     (use_rs2_id & (rs2_if2id_ff == rd_id2ex_ff)));
  assign timeout  = (state_q == S_MEM) & ~dmem_ack & (wcnt_q == WCW'(MEM_TIMEOUT));
  assign cause    = hazard_pick(mem_wait, mdu_start_ex, branch_taken_ex, load_use);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    mdu_go    = 1'b0;
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pend_d    = pend_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        case (cause)
          HZ_MEM: begin
            {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
            state_d = S_MEM;
            wcnt_d  = WCW'(1);
            pend_d  = mdu_start_ex;
          end
          HZ_MDU: begin
            {stall_if, stall_id, stall_ex, flush_mem, mdu_go} = '1;
            state_d = S_MDU;
          end
          HZ_BRANCH:   {flush_id, flush_ex} = '1;
          HZ_LOAD_USE: {stall_if, stall_id, flush_ex} = '1;
          default: ;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          // Give up on the access: drop the stalls and let WB take a bubble.
          flush_wb  = 1'b1;
          bus_err_d = 1'b1;
          state_d   = S_RUN;
          wcnt_d    = '0;
          pend_d    = 1'b0;
        end else begin
          {stall_if, stall_id, stall_ex, stall_mem} = '1;
          flush_wb = ~dmem_ack;
          wcnt_d   = wcnt_q + WCW'(1);
          if (dmem_ack) begin
            mdu_go  = pend_q;
            state_d = pend_q ? S_MDU : S_RUN;
            wcnt_d  = '0;
            pend_d  = 1'b0;
          end
        end
      end
      S_MDU: begin
        if (mem_wait) {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
        else          {stall_if, stall_id, stall_ex, flush_mem} = '1;
        if (mdu_done) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      wcnt_q    <= '0;
      pend_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pend_q    <= pend_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

  riscv_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .clr   (clr_cnt),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl with a short memory timeout and narrow stall counter.
module tb_riscv_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, mem_read, mdu_start, mdu_done, branch, dreq, dack, clr;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_mem, flush_wb, mdu_go, bus_err;
  logic [2:0] stall_cnt;
  logic [9:0] ctl;

  int checks = 0;
  int failures = 0;

  // Bit order: {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,flush_mem,flush_wb,mdu_go,bus_err}
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_LU    = 10'b1100010000;
  localparam logic [9:0] C_BR    = 10'b0000110000;
  localparam logic [9:0] C_GO    = 10'b1110001010;
  localparam logic [9:0] C_MDU   = 10'b1110001000;
  localparam logic [9:0] C_MEM   = 10'b1111000100;
  localparam logic [9:0] C_ACK   = 10'b1111000000;
  localparam logic [9:0] C_ACKGO = 10'b1111000010;
  localparam logic [9:0] C_TO    = 10'b0000000100;
  localparam logic [9:0] C_BERR  = 10'b0000000001;

  assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                flush_mem, flush_wb, mdu_go, bus_err};

  riscv_hazard_ctrl #(.RF_ADDR_WIDTH(5), .MEM_TIMEOUT(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_if2id_ff(rs1), .rs2_if2id_ff(rs2), .use_rs1_id(use_rs1), .use_rs2_id(use_rs2),
    .rd_id2ex_ff(rd), .mem_read_id2ex_ff(mem_read),
    .mdu_start_ex(mdu_start), .mdu_done(mdu_done), .branch_taken_ex(branch),
    .dmem_req_mem(dreq), .dmem_ack(dack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .mdu_go(mdu_go), .bus_err(bus_err), .stall_cnt(stall_cnt), .clr_cnt(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    use_rs1 = 0; use_rs2 = 0; mem_read = 0; mdu_start = 0; mdu_done = 0;
    branch = 0; dreq = 0; dack = 0; clr = 0;
  endtask

  task automatic load_use_rs2(input logic [4:0] r);
    idle(); mem_read = 1; rd = r; rs2 = r; use_rs2 = 1;
  endtask

  initial begin
    load_use_rs2(5'd5);
    @(negedge clk); #1;
    chk("reset_ctl", ctl, C_NONE);
    chk("reset_cnt", stall_cnt, 0);

    @(negedge clk); rst_n = 1; #1;
    chk("init_cycle_no_stall", ctl, C_NONE);
    @(negedge clk); #1;
    chk("lu_rs2_x5", ctl, C_LU);
    @(negedge clk); load_use_rs2(5'd0); #1;
    chk("lu_rd_x0", ctl, C_NONE);
    chk("cnt_after_lu", stall_cnt, 1);
    @(negedge clk); idle(); mem_read = 1; rd = 7; rs1 = 7; #1;
    chk("lu_rs1_unused", ctl, C_NONE);
    @(negedge clk); use_rs1 = 1; #1;
    chk("lu_rs1_x7", ctl, C_LU);
    @(negedge clk); mem_read = 0; #1;
    chk("no_load_no_stall", ctl, C_NONE);
    chk("cnt_two_lu", stall_cnt, 2);

    @(negedge clk); mem_read = 1; branch = 1; #1;
    chk("branch_masks_lu", ctl, C_BR);
    @(negedge clk); idle(); #1;
    chk("branch_one_cycle", ctl, C_NONE);

    @(negedge clk); clr = 1; #1;
    chk("clr_cycle", ctl, C_NONE);
    @(negedge clk); clr = 0; mdu_start = 1; #1;
    chk("mdu_go", ctl, C_GO);
    chk("cnt_cleared", stall_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mdu_busy", ctl, C_MDU);
    end
    @(negedge clk); mdu_done = 1; #1;
    chk("mdu_done_stalled", ctl, C_MDU);
    @(negedge clk); idle(); #1;
    chk("mdu_released", ctl, C_NONE);
    chk("cnt_mdu_5", stall_cnt, 5);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_use_rs2(5'd9); #1;
      chk("sat_lu", ctl, C_LU);
    end
    @(negedge clk); idle(); #1;
    chk("cnt_saturated", stall_cnt, 7);
    @(negedge clk); load_use_rs2(5'd9); clr = 1; #1;
    chk("clr_with_stall", ctl, C_LU);
    @(negedge clk); idle(); #1;
    chk("clr_beats_inc", stall_cnt, 0);

    @(negedge clk); dreq = 1; #1;
    chk("mem_wait1", ctl, C_MEM);
    @(negedge clk); #1;
    chk("mem_wait2", ctl, C_MEM);
    @(negedge clk); dack = 1; #1;
    chk("mem_ack3", ctl, C_ACK);
    @(negedge clk); idle(); #1;
    chk("mem_done", ctl, C_NONE);

    @(negedge clk); dreq = 1; #1;
    chk("to_wait1", ctl, C_MEM);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("to_wait", ctl, C_MEM);
    end
    @(negedge clk); #1;
    chk("to_release", ctl, C_TO);
    @(negedge clk); idle(); #1;
    chk("bus_err_pulse", ctl, C_BERR);
    @(negedge clk); #1;
    chk("bus_err_once", ctl, C_NONE);

    @(negedge clk); dreq = 1; mdu_start = 1; branch = 1; #1;
    chk("combo_mem_only", ctl, C_MEM);
    @(negedge clk); #1;
    chk("combo_mem_hold", ctl, C_MEM);
    @(negedge clk); dack = 1; #1;
    chk("combo_ack_go", ctl, C_ACKGO);
    @(negedge clk); dreq = 0; dack = 0; #1;
    chk("combo_mdu_busy", ctl, C_MDU);
    @(negedge clk); mdu_done = 1; #1;
    chk("combo_mdu_done", ctl, C_MDU);
    @(negedge clk); mdu_done = 0; mdu_start = 0; #1;
    chk("combo_branch", ctl, C_BR);
    @(negedge clk); idle(); #1;
    chk("combo_idle", ctl, C_NONE);

    @(negedge clk); dreq = 1; #1;
    chk("rst_mem_enter", ctl, C_MEM);
    @(negedge clk); #1;
    chk("rst_mem_hold", ctl, C_MEM);
    #2 rst_n = 0; #1;
    chk("async_reset_ctl", ctl, C_NONE);
    repeat (6) @(negedge clk);
    #1;
    chk("reset_no_bus_err", ctl, C_NONE);
    @(negedge clk); idle(); rst_n = 1; #1;
    chk("rerelease_init", ctl, C_NONE);
    @(negedge clk); #1;
    chk("rerelease_run", ctl, C_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
